// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the shared-memory arbiter slice.
//   - state_t : arbiter FSM states (DRAIN, IDLE, FILL, WRITE)
//   - owner_t : which cache owns the current operation (I=0, D=1)
//   - BLOCK_WORDS, MEM_LATENCY, IDX_W, BLOCK_OFF_MASK
package mem_arbiter_pkg;

  localparam int BLOCK_WORDS = 8;   // 16-bit words per cache block
  localparam int MEM_LATENCY = 4;   // read latency, also post-reset drain length
  localparam int IDX_W       = 3;   // width of a word index inside a block

  // Byte-offset bits inside a 16-byte block.
  localparam logic [3:0] BLOCK_OFF_MASK = 4'hF;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FILL  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the arbiter.
//   slave  modport : the arbiter (receives cache requests, drives memory commands)
//   master modport : the environment (caches and memory)
//
// Handshake: a cache raises *_req with a stable address and holds it until
// the arbiter answers with *_done (fills) or dc_wr_ack (stores); the cache
// drops req in the following cycle. A req still high while the arbiter is
// idle is taken as a new request. Fill words are transfer-valid only in
// cycles where the owner's *_fill_valid is high; there is no back-pressure.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  // I-cache
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_fill_valid;
  logic                  ic_done;
  // D-cache
  logic                  dc_req;
  logic                  dc_wr;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [15:0]           dc_wdata;
  logic                  dc_fill_valid;
  logic                  dc_done;
  logic                  dc_wr_ack;
  // Shared return path
  logic [15:0]           fill_data;
  logic [2:0]            fill_idx;
  // Memory
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;
  logic [15:0]           mem_data_out;
  logic                  mem_data_valid;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata,
    input  mem_data_out, mem_data_valid,
    output ic_fill_valid, ic_done, dc_fill_valid, dc_done, dc_wr_ack,
    output fill_data, fill_idx,
    output mem_enable, mem_wr, mem_addr, mem_data_in
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata,
    output mem_data_out, mem_data_valid,
    input  ic_fill_valid, ic_done, dc_fill_valid, dc_done, dc_wr_ack,
    input  fill_data, fill_idx,
    input  mem_enable, mem_wr, mem_addr, mem_data_in
  );

endinterface

// File: rtl/mem_fill_seq.sv
// mem_fill_seq: block-fill sequencer.
//   clk, rst        : clock, async active-low reset
//   start, base     : load block base and clear counters (arbiter grants a fill)
//   active          : arbiter is in FILL
//   mem_data_valid  : read data returning from memory
//   issue_en/addr   : read command for word k (k = 0..7), zero when idle
//   ret_valid/idx   : counted return and its word index (idx zero when idle)
//   ret_last        : the 8th return of the block
module mem_fill_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  active,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  mem_data_valid,
  output logic                  issue_en,
  output logic [ADDR_WIDTH-1:0] issue_addr,
  output logic                  ret_valid,
  output logic [IDX_W-1:0]      ret_idx,
  output logic                  ret_last
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W:0]        issue_cnt;  // one extra bit: reaching 8 means all issued
  logic [IDX_W-1:0]      ret_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (start) begin
      base_q    <= base;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (active) begin
      if (issue_en)  issue_cnt <= issue_cnt + 1'b1;
      if (ret_valid) ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  assign issue_en   = active && (issue_cnt < (IDX_W+1)'(BLOCK_WORDS));
  // Word k lives at base + 2k; the add wraps naturally at ADDR_WIDTH bits.
  assign issue_addr = issue_en ? base_q + ADDR_WIDTH'({issue_cnt[IDX_W-1:0], 1'b0}) : '0;
  assign ret_valid  = active && mem_data_valid;
  assign ret_idx    = ret_valid ? ret_cnt : '0;
  assign ret_last   = ret_valid && (ret_cnt == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between I-cache and D-cache miss handlers
// in front of a single pipelined memory.
//   clk, rst  : clock, async active-low reset
//   bus       : mem_arbiter_if.slave (cache requests/returns, memory command)
//   dbg_state : current FSM state
// Fills are 8 pipelined reads; D-cache stores are single-cycle writes.
// Return data/valid/index are combinational from the memory's read port,
// memory commands are decoded from registered state only.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output state_t        dbg_state
);

  localparam logic [2:0] DRAIN_LAST = 3'(MEM_LATENCY - 1);

  state_t                state;
  owner_t                owner;
  owner_t                last_grant;
  logic [2:0]            drain_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  owner_t                winner;
  logic                  any_req;
  logic                  win_store;
  logic                  fill_start;
  logic [ADDR_WIDTH-1:0] fill_base;

  logic                  seq_issue;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  seq_ret_valid;
  logic [IDX_W-1:0]      seq_ret_idx;
  logic                  seq_ret_last;

  // On a tie, grant whichever side was not granted last.
  always_comb begin
    any_req = bus.ic_req | bus.dc_req;
    if (bus.ic_req && bus.dc_req)
      winner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    else if (bus.dc_req)
      winner = OWN_D;
    else
      winner = OWN_I;
    win_store  = (winner == OWN_D) && bus.dc_wr;
    fill_start = (state == ST_IDLE) && any_req && !win_store;
    fill_base  = ((winner == OWN_D) ? bus.dc_addr : bus.ic_addr)
                 & ~ADDR_WIDTH'(BLOCK_OFF_MASK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_DRAIN;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      drain_cnt  <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        // Reads in flight at reset still return; wait them out.
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_grant <= winner;
            if (win_store) begin
              wr_addr <= {bus.dc_addr[ADDR_WIDTH-1:1], 1'b0};
              wr_data <= bus.dc_wdata;
              state   <= ST_WRITE;
            end else begin
              state   <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (seq_ret_last) state <= ST_IDLE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

  mem_fill_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill_seq (
    .clk            (clk),
    .rst            (rst),
    .start          (fill_start),
    .active         (state == ST_FILL),
    .base           (fill_base),
    .mem_data_valid (bus.mem_data_valid),
    .issue_en       (seq_issue),
    .issue_addr     (seq_addr),
    .ret_valid      (seq_ret_valid),
    .ret_idx        (seq_ret_idx),
    .ret_last       (seq_ret_last)
  );

  assign bus.mem_enable    = seq_issue || (state == ST_WRITE);
  assign bus.mem_wr        = (state == ST_WRITE);
  assign bus.mem_addr      = (state == ST_WRITE) ? wr_addr : seq_addr;
  assign bus.mem_data_in   = (state == ST_WRITE) ? wr_data : '0;
  assign bus.dc_wr_ack     = (state == ST_WRITE);

  assign bus.ic_fill_valid = seq_ret_valid && (owner == OWN_I);
  assign bus.dc_fill_valid = seq_ret_valid && (owner == OWN_D);
  assign bus.ic_done       = seq_ret_last && (owner == OWN_I);
  assign bus.dc_done       = seq_ret_last && (owner == OWN_D);
  assign bus.fill_data     = seq_ret_valid ? bus.mem_data_out : '0;
  assign bus.fill_idx      = seq_ret_idx;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit last_served;  // 0 = I, 1 = D : who the arbiter should have granted last

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model (4-cycle pipelined read) ----------------
  logic [15:0] seed;
  logic [15:0] mem_wdata   [0:32767];
  bit          mem_written [0:32767];
  logic [3:0]  pipe_v = '0;
  logic [15:0] pipe_d [0:3];
  logic        stray_v;
  logic [15:0] stray_d;

  function automatic logic [15:0] pattern(input logic [14:0] w);
    return 16'({1'b0, w} * 16'h9E37) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) begin
      mem_wdata[bus.mem_addr[15:1]]   <= bus.mem_data_in;
      mem_written[bus.mem_addr[15:1]] <= 1'b1;
    end
    pipe_v[0] <= bus.mem_enable && !bus.mem_wr;
    pipe_d[0] <= mem_written[bus.mem_addr[15:1]] ? mem_wdata[bus.mem_addr[15:1]]
                                                 : pattern(bus.mem_addr[15:1]);
    for (int i = 1; i < 4; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign bus.mem_data_valid = pipe_v[3] | stray_v;
  assign bus.mem_data_out   = stray_v ? stray_d : pipe_d[3];

  // ---------------- reference memory contents ----------------
  logic [15:0] ref_data    [0:32767];
  bit          ref_written [0:32767];

  function automatic logic [15:0] ref_rd(input logic [14:0] w);
    return ref_written[w] ? ref_data[w] : pattern(w);
  endfunction

  function automatic logic [57:0] all_outs();
    return {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in,
            bus.ic_fill_valid, bus.dc_fill_valid, bus.fill_data, bus.fill_idx,
            bus.ic_done, bus.dc_done, bus.dc_wr_ack};
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge. Cycle 0 = request seen in IDLE.
  task automatic run_fill(input bit is_d, input logic [15:0] addr, input int drop_at, input bit keep);
    logic [15:0] exp_q[$];
    logic [15:0] base, exp_addr, exp_d;
    logic [14:0] w;
    logic [2:0]  exp_idx;
    bit          exp_en, exp_v, own_v, oth_v, own_done, oth_done;
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      w = base[15:1] + 15'(i);
      exp_q.push_back(ref_rd(w));
    end
    if (is_d) begin bus.dc_req = 1'b1; bus.dc_wr = 1'b0; bus.dc_addr = addr; end
    else begin bus.ic_req = 1'b1; bus.ic_addr = addr; end
    for (int c = 0; c <= 12; c++) begin
      if (c == drop_at) begin
        if (is_d) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
      end
      @(negedge clk);
      exp_en   = (c >= 1 && c <= 8);
      exp_addr = exp_en ? 16'(base + 16'(2 * (c - 1))) : 16'h0000;
      n_checks++;
      if ({bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in} !== {exp_en, 1'b0, exp_addr, 16'h0000}) begin
        n_errors++;
        $display("FAIL fill_cmd c=%0d: got en=%b wr=%b addr=%h din=%h, want en=%b wr=0 addr=%h din=0000",
                 c, bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, exp_en, exp_addr);
      end
      own_v    = is_d ? bus.dc_fill_valid : bus.ic_fill_valid;
      oth_v    = is_d ? bus.ic_fill_valid : bus.dc_fill_valid;
      own_done = is_d ? bus.dc_done : bus.ic_done;
      oth_done = is_d ? bus.ic_done : bus.dc_done;
      exp_v    = (c >= 5 && c <= 12);
      n_checks++;
      if ({own_v, oth_v, own_done, oth_done, bus.dc_wr_ack} !== {exp_v, 1'b0, (c == 12), 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL fill_flags c=%0d owner=%0d: got v=%b ov=%b done=%b odone=%b ack=%b, want v=%b ov=0 done=%b odone=0 ack=0",
                 c, is_d, own_v, oth_v, own_done, oth_done, bus.dc_wr_ack, exp_v, (c == 12));
      end
      if (exp_v) begin
        exp_d   = exp_q.pop_front();
        exp_idx = 3'(c - 5);
        n_checks++;
        if ({bus.fill_idx, bus.fill_data} !== {exp_idx, exp_d}) begin
          n_errors++;
          $display("FAIL fill_word c=%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                   c, bus.fill_idx, bus.fill_data, exp_idx, exp_d);
        end
      end
      @(posedge clk); #1;
    end
    if (!keep) begin
      if (is_d) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
    end
    last_served = is_d;
  endtask

  task automatic run_store(input logic [15:0] addr, input logic [15:0] data);
    bus.dc_req = 1'b1; bus.dc_wr = 1'b1; bus.dc_addr = addr; bus.dc_wdata = data;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_enable, bus.dc_wr_ack} !== 2'b00) begin
      n_errors++;
      $display("FAIL store_c0: got en=%b ack=%b, want 0 0", bus.mem_enable, bus.dc_wr_ack);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.dc_wr_ack, bus.dc_done}
        !== {1'b1, 1'b1, addr & 16'hFFFE, data, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL store_c1: got en=%b wr=%b addr=%h din=%h ack=%b, want en=1 wr=1 addr=%h din=%h ack=1",
               bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.dc_wr_ack, addr & 16'hFFFE, data);
    end
    ref_data[addr[15:1]]    = data;
    ref_written[addr[15:1]] = 1'b1;
    @(posedge clk); #1;
    bus.dc_req = 1'b0; bus.dc_wr = 1'b0;
    last_served = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({all_outs(), dbg_state} !== {58'h0, ST_DRAIN}) begin
        n_errors++;
        $display("FAIL reset_outs: got outs=%h state=%0d, want 0 and DRAIN", all_outs(), dbg_state);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.ic_req = 1'b1; bus.ic_addr = 16'h0046;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_enable, bus.ic_fill_valid, bus.dc_fill_valid} !== 3'b000) begin
        n_errors++;
        $display("FAIL drain_no_grant i=%0d: got en=%b iv=%b dv=%b, want 0 0 0",
                 i, bus.mem_enable, bus.ic_fill_valid, bus.dc_fill_valid);
      end
      @(posedge clk); #1;
    end
    last_served = 1'b0;
    run_fill(1'b0, 16'h0046, -1, 1'b0);
  endtask

  task automatic test_tie();
    bus.ic_req = 1'b1; bus.ic_addr = 16'h2200;
    bus.dc_req = 1'b1; bus.dc_wr = 1'b0; bus.dc_addr = 16'h3300;
    run_fill(1'b1, 16'h3300, -1, 1'b1);   // D first; D keeps requesting
    bus.dc_addr = 16'h4410;
    run_fill(1'b0, 16'h2200, -1, 1'b0);   // repeated tie goes to I
    run_fill(1'b1, 16'h4410, -1, 1'b0);   // then D
  endtask

  task automatic test_store();
    run_store(16'h1235, 16'hBEEF);
    run_fill(1'b1, 16'h1230, -1, 1'b0);
  endtask

  task automatic test_wrap_stray();
    run_fill(1'b1, 16'hFFF8, -1, 1'b0);
    stray_v = 1'b1; stray_d = 16'($urandom);
    @(negedge clk);
    n_checks++;
    if ({bus.ic_fill_valid, bus.dc_fill_valid, bus.fill_data, bus.fill_idx, bus.ic_done, bus.dc_done, bus.mem_enable}
        !== 25'h0) begin
      n_errors++;
      $display("FAIL stray_idle: got iv=%b dv=%b data=%h idx=%0d en=%b, want all 0",
               bus.ic_fill_valid, bus.dc_fill_valid, bus.fill_data, bus.fill_idx, bus.mem_enable);
    end
    @(posedge clk); #1;
    stray_v = 1'b0;
    run_fill(1'b0, 16'($urandom), -1, 1'b0);
  endtask

  task automatic test_drop();
    run_fill(1'b0, 16'($urandom), 3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_enable, dbg_state} !== {1'b0, ST_IDLE}) begin
        n_errors++;
        $display("FAIL drop_idle i=%0d: got en=%b state=%0d, want 0 IDLE", i, bus.mem_enable, dbg_state);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.ic_req = 1'b1; bus.ic_addr = 16'($urandom);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin
        n_checks++;
        if (bus.ic_fill_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL rmf_first_word: got iv=%b, want 1", bus.ic_fill_valid);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.ic_req = 1'b0;   // cycle 6, second return in flight
    #1;
    n_checks++;
    if (all_outs() !== 58'h0) begin
      n_errors++;
      $display("FAIL rmf_async: got outs=%h, want 0", all_outs());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    last_served = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.mem_enable, bus.ic_fill_valid, bus.dc_fill_valid, bus.ic_done, bus.dc_done} !== 5'b0) begin
        n_errors++;
        $display("FAIL rmf_drain c=%0d: got en=%b iv=%b dv=%b idone=%b ddone=%b, want all 0",
                 c, bus.mem_enable, bus.ic_fill_valid, bus.dc_fill_valid, bus.ic_done, bus.dc_done);
      end
      @(posedge clk); #1;
    end
    run_fill(1'b0, 16'($urandom), -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.ic_fill_valid, bus.dc_fill_valid, bus.ic_done} !== 3'b0) begin
        n_errors++;
        $display("FAIL rmf_extra_word i=%0d: got iv=%b dv=%b done=%b, want 0",
                 i, bus.ic_fill_valid, bus.dc_fill_valid, bus.ic_done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    bit          first;
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: run_fill(1'b0, a, $urandom_range(1, 12), 1'b0);
        1: run_fill(1'b1, a, $urandom_range(1, 12), 1'b0);
        2: begin
          run_store(a, b);
          if ($urandom_range(0, 1) == 1) run_fill(1'($urandom_range(0, 1)), a, -1, 1'b0);
        end
        default: begin
          // tie: the side not served last must win, then the other side
          first = !last_served;
          bus.ic_req = 1'b1; bus.ic_addr = first ? b : a;
          bus.dc_req = 1'b1; bus.dc_wr = 1'b0; bus.dc_addr = first ? a : b;
          run_fill(first, a, -1, 1'b0);
          run_fill(!first, b, -1, 1'b0);
        end
      endcase
    end
  endtask

  // ---------------- main ----------------
  initial begin
    seed = 16'($urandom);
    rst = 1'b0;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.dc_req = 1'b0; bus.dc_wr = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
    stray_v = 1'b0; stray_d = '0;
    last_served = 1'b0;
    test_reset();
    test_tie();
    test_store();
    test_wrap_stray();
    test_drop();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
